fp_op_sequencer: RTL and testbench

Single-issue controller between the FP execute stage and the three FP arithmetic units: the add/sub unit (single-cycle result), the multiplier (strobe/ack handshake) and the Newton divider (busy-driven, multi-cycle). It accepts one operation at a time over a valid/ready request port and steers the operands to the selected unit. It follows that unit's start/completion protocol, guards every wait with a timeout, and returns the result over a valid/ready response port.

---
 rtl/fp_op_sequencer_if.sv | 77 +++++++
 rtl/fp_op_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_op_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_op_sequencer_if.sv
// Bundle of the request/response handshakes and the three FP unit
// connections of fp_op_sequencer.
//
// Signal groups:
//   req_*          valid/ready request port from the execute stage
//   rsp_*          valid/ready response port back to the execute stage
//   unit_a/unit_b  registered operands shared by all units
//   as_*           add/sub unit (single-cycle, combinational result)
//   mul_*          multiplier (operand strobe/ack, result strobe/ack)
//   div_*          divider (start pulse, busy, result)
//
// Modports:
//   slave   the sequencer itself
//   master  its environment (execute stage plus the arithmetic units)
interface fp_op_sequencer_if;
  // Request port
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;

  // Response port
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_op;
  logic        rsp_err;

  // Shared operands
  logic [31:0] unit_a;
  logic [31:0] unit_b;

  // Add/sub unit
  logic        as_sub;
  logic [31:0] as_result;

  // Multiplier
  logic        mul_strb;
  logic        mul_ack;
  logic        mul_result_stb;
  logic        mul_result_ack;
  logic [31:0] mul_result;

  // Divider
  logic        div_start;
  logic        div_busy;
  logic [31:0] div_result;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output rsp_valid, rsp_result, rsp_op, rsp_err,
    input  rsp_ready,
    output unit_a, unit_b,
    output as_sub,
    input  as_result,
    output mul_strb, mul_result_ack,
    input  mul_ack, mul_result_stb, mul_result,
    output div_start,
    input  div_busy, div_result
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_op, rsp_err,
    output rsp_ready,
    input  unit_a, unit_b,
    input  as_sub,
    output as_result,
    input  mul_strb, mul_result_ack,
    output mul_ack, mul_result_stb, mul_result,
    input  div_start,
    output div_busy, div_result
  );
endinterface

// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: single-issue controller between the FP execute stage and
// the add/sub, multiply and divide units. One operation is accepted at a
// time, its operands are registered onto unit_a/unit_b, the selected unit's
// start/completion protocol is followed, and the result is returned on the
// response port. Every wait on a unit is bounded by TIMEOUT cycles; an
// expired wait returns a quiet NaN with rsp_err set.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  fp_op_sequencer_if.slave (request, response and unit signals)
//
// Parameters:
//   TIMEOUT  maximum cycles spent in a unit-wait state before aborting
//   CNT_W    wait counter width; 2**CNT_W must exceed TIMEOUT
module fp_op_sequencer #(
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned CNT_W   = 6
) (
  input logic              clk,
  input logic              rst,
  fp_op_sequencer_if.slave bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StAddSub,
    StMulReq,
    StMulWait,
    StDivStart,
    StDivWait,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] unit_a_q, unit_a_d;
  logic [31:0] unit_b_q, unit_b_d;
  logic        as_sub_q, as_sub_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [1:0]  rsp_op_q, rsp_op_d;
  logic        rsp_err_q, rsp_err_d;

  // Unregistered Moore/Mealy outputs before reset gating
  logic req_ready_c;
  logic rsp_valid_c;
  logic mul_strb_c;
  logic mul_result_ack_c;
  logic div_start_c;

  logic timeout;
  logic in_wait;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT));
  assign in_wait = (state_q == StMulReq)   || (state_q == StMulWait) ||
                   (state_q == StDivStart) || (state_q == StDivWait);

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      as_sub_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      unit_a_q     <= unit_a_d;
      unit_b_q     <= unit_b_d;
      as_sub_q     <= as_sub_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    unit_a_d         = unit_a_q;
    unit_b_d         = unit_b_q;
    as_sub_d         = as_sub_q;
    rsp_result_d     = rsp_result_q;
    rsp_op_d         = rsp_op_q;
    rsp_err_d        = rsp_err_q;
    req_ready_c      = 1'b0;
    rsp_valid_c      = 1'b0;
    mul_strb_c       = 1'b0;
    mul_result_ack_c = 1'b0;
    div_start_c      = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          unit_a_d = bus.req_a;
          unit_b_d = bus.req_b;
          as_sub_d = (bus.req_op == OP_SUB);
          rsp_op_d = bus.req_op;
          if (bus.req_op == OP_ADD || bus.req_op == OP_SUB) begin
            state_d = StAddSub;
          end else if (bus.req_op == OP_MUL) begin
            state_d = StMulReq;
          end else begin
            state_d = StDivStart;
          end
        end
      end

      StAddSub: begin
        // The add/sub unit is combinational on unit_a/unit_b/as_sub
        rsp_result_d = bus.as_result;
        rsp_err_d    = 1'b0;
        state_d      = StResp;
      end

      StMulReq: begin
        mul_strb_c = 1'b1;
        // A completion in the timeout cycle still counts as a completion
        if (bus.mul_ack) begin
          state_d = StMulWait;
        end else if (timeout) begin
          rsp_result_d = QNAN;
          rsp_err_d    = 1'b1;
          state_d      = StResp;
        end
      end

      StMulWait: begin
        if (bus.mul_result_stb) begin
          mul_result_ack_c = 1'b1;
          rsp_result_d     = bus.mul_result;
          rsp_err_d        = 1'b0;
          state_d          = StResp;
        end else if (timeout) begin
          rsp_result_d = QNAN;
          rsp_err_d    = 1'b1;
          state_d      = StResp;
        end
      end

      StDivStart: begin
        // Only start a divider that is not still busy with earlier work
        if (!bus.div_busy) begin
          div_start_c = 1'b1;
          state_d     = StDivWait;
        end else if (timeout) begin
          rsp_result_d = QNAN;
          rsp_err_d    = 1'b1;
          state_d      = StResp;
        end
      end

      StDivWait: begin
        // cnt_q == 0 marks the cycle right after the start pulse, before the
        // divider has had a chance to raise busy; that sample is ignored.
        if ((cnt_q != '0) && !bus.div_busy) begin
          rsp_result_d = bus.div_result;
          rsp_err_d    = 1'b0;
          state_d      = StResp;
        end else if (timeout) begin
          rsp_result_d = QNAN;
          rsp_err_d    = 1'b1;
          state_d      = StResp;
        end
      end

      StResp: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Wait counter: cleared on every state change (which covers entry into each
  // wait state), counting while a wait state is held.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && in_wait) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Unregistered outputs are forced low while rst is high so that
  // strobes drop and req_ready reads 0 for the whole reset period.
  // ---------------------------------------------------------------------------
  assign bus.req_ready      = req_ready_c      & ~rst;
  assign bus.rsp_valid      = rsp_valid_c      & ~rst;
  assign bus.mul_strb       = mul_strb_c       & ~rst;
  assign bus.mul_result_ack = mul_result_ack_c & ~rst;
  assign bus.div_start      = div_start_c      & ~rst;

  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.unit_a     = unit_a_q;
  assign bus.unit_b     = unit_b_q;
  assign bus.as_sub     = as_sub_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed bench for fp_op_sequencer. Inputs change 1 time unit after a
// rising edge; outputs are sampled before the next rising edge.
module tb_fp_op_sequencer;

  localparam int unsigned TIMEOUT = 63;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  fp_op_sequencer_if bus ();

  fp_op_sequencer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    #1;
    check("req_ready_at_accept", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int k;
    checks = 0;
    passes = 0;
    rst                = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_op         = 2'd0;
    bus.req_a          = '0;
    bus.req_b          = '0;
    bus.rsp_ready      = 1'b1;
    bus.as_result      = '0;
    bus.mul_ack        = 1'b0;
    bus.mul_result_stb = 1'b0;
    bus.mul_result     = '0;
    bus.div_busy       = 1'b0;
    bus.div_result     = '0;

    // ---------------- Reset ----------------
    step();
    step();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_rst_flags", {24'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_op, bus.as_sub,
                             bus.mul_strb, bus.mul_result_ack, bus.div_start}, 32'd0);
    check("post_rst_result", bus.rsp_result, 32'd0);
    check("post_rst_unit_a", bus.unit_a, 32'd0);
    check("post_rst_unit_b", bus.unit_b, 32'd0);

    // ---------------- ADD 1.0 + 2.0 ----------------
    bus.as_result = 32'h4040_0000;
    issue(2'd0, 32'h3F80_0000, 32'h4000_0000);
    check("add_c1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("add_c1_req_ready", 32'(bus.req_ready), 32'd0);
    check("add_unit_a", bus.unit_a, 32'h3F80_0000);
    check("add_unit_b", bus.unit_b, 32'h4000_0000);
    check("add_as_sub", 32'(bus.as_sub), 32'd0);
    step();
    check("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("add_result", bus.rsp_result, 32'h4040_0000);
    check("add_rsp_op", 32'(bus.rsp_op), 32'd0);
    check("add_rsp_err", 32'(bus.rsp_err), 32'd0);
    step();
    check("add_back_idle", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);

    // ---------------- SUB with response back-pressure ----------------
    bus.rsp_ready = 1'b0;
    bus.as_result = 32'h4000_0000;
    issue(2'd1, 32'h4040_0000, 32'h3F80_0000);
    check("sub_as_sub", 32'(bus.as_sub), 32'd1);
    step();
    bus.as_result = 32'hDEAD_BEEF;   // must not leak into the held response
    for (int i = 0; i < 5; i++) begin
      check("sub_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("sub_hold_result", bus.rsp_result, 32'h4000_0000);
      check("sub_hold_op", 32'(bus.rsp_op), 32'd1);
      check("sub_hold_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("sub_handshake_valid", 32'(bus.rsp_valid), 32'd1);
    step();
    check("sub_back_idle", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);

    // ---------------- MUL with delayed ack ----------------
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd2;
    bus.req_a     = 32'h4000_0000;
    bus.req_b     = 32'h4040_0000;
    #1;
    check("mul_strb_at_accept", 32'(bus.mul_strb), 32'd0);
    step();
    bus.req_valid = 1'b0;
    check("mul_strb_c0", 32'(bus.mul_strb), 32'd1);
    check("mul_unit_b", bus.unit_b, 32'h4040_0000);
    step();
    check("mul_strb_c1", 32'(bus.mul_strb), 32'd1);
    step();
    bus.mul_ack = 1'b1;
    #1;
    check("mul_strb_c2", 32'(bus.mul_strb), 32'd1);
    step();
    bus.mul_ack = 1'b0;
    check("mul_strb_dropped", 32'(bus.mul_strb), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("mul_rack_idle", 32'(bus.mul_result_ack), 32'd0);
      step();
    end
    bus.mul_result_stb = 1'b1;
    bus.mul_result     = 32'h40C0_0000;
    #1;
    check("mul_rack_pulse", 32'(bus.mul_result_ack), 32'd1);
    step();
    bus.mul_result_stb = 1'b0;
    bus.mul_result     = 32'h0;
    check("mul_rack_after", 32'(bus.mul_result_ack), 32'd0);
    check("mul_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("mul_result", bus.rsp_result, 32'h40C0_0000);
    check("mul_rsp_op_err", {29'd0, bus.rsp_op, bus.rsp_err}, 32'h4);
    step();

    // ---------------- DIV issued while divider busy ----------------
    bus.div_busy = 1'b1;
    issue(2'd3, 32'h3F80_0000, 32'h4000_0000);
    for (int i = 0; i < 4; i++) begin
      check("div_no_start_while_busy", 32'(bus.div_start), 32'd0);
      step();
    end
    bus.div_busy = 1'b0;
    #1;
    check("div_start_pulse", 32'(bus.div_start), 32'd1);
    step();
    bus.div_busy   = 1'b1;
    bus.div_result = 32'h1234_5678;
    for (int i = 0; i < 25; i++) begin
      check("div_wait_no_start", {30'd0, bus.div_start, bus.rsp_valid}, 32'd0);
      step();
    end
    bus.div_busy   = 1'b0;
    bus.div_result = 32'h3F00_0000;
    step();
    bus.div_result = 32'h0;
    check("div_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("div_result", bus.rsp_result, 32'h3F00_0000);
    check("div_rsp_op_err", {29'd0, bus.rsp_op, bus.rsp_err}, 32'h6);
    step();

    // ---------------- DIV: first wait cycle busy sample ignored ----------------
    issue(2'd3, 32'h4000_0000, 32'h4000_0000);
    check("div2_start", 32'(bus.div_start), 32'd1);
    step();
    bus.div_result = 32'h3F80_0000;   // busy still low: must be ignored
    step();
    check("div2_first_ignored", 32'(bus.rsp_valid), 32'd0);
    bus.div_busy = 1'b1;
    step();
    step();
    bus.div_busy = 1'b0;
    step();
    check("div2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("div2_result", bus.rsp_result, 32'h3F80_0000);
    step();

    // ---------------- MUL timeout: never acked ----------------
    issue(2'd2, 32'h4000_0000, 32'h4000_0000);
    k = 0;
    while (bus.rsp_valid !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    check("multo_latency", 32'(k), 32'(TIMEOUT + 1));
    check("multo_result", bus.rsp_result, 32'h7FC0_0000);
    check("multo_err", 32'(bus.rsp_err), 32'd1);
    check("multo_strb_low", 32'(bus.mul_strb), 32'd0);
    check("multo_op", 32'(bus.rsp_op), 32'd2);
    step();

    // ---------------- MUL ack in the timeout cycle: completion wins ----------------
    issue(2'd2, 32'h4000_0000, 32'h4080_0000);
    for (int i = 0; i < int'(TIMEOUT); i++) step();
    bus.mul_ack = 1'b1;
    #1;
    check("mulrace_strb_still_high", 32'(bus.mul_strb), 32'd1);
    step();
    bus.mul_ack = 1'b0;
    check("mulrace_no_abort", 32'(bus.rsp_valid), 32'd0);
    bus.mul_result_stb = 1'b1;
    bus.mul_result     = 32'h4100_0000;
    step();
    bus.mul_result_stb = 1'b0;
    check("mulrace_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("mulrace_err", 32'(bus.rsp_err), 32'd0);
    check("mulrace_result", bus.rsp_result, 32'h4100_0000);
    step();

    // ---------------- Reset in the middle of DIV_WAIT ----------------
    issue(2'd3, 32'h4040_0000, 32'h4000_0000);
    step();
    bus.div_busy = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    rst          = 1'b0;
    bus.div_busy = 1'b0;
    #1;
    check("midrst_flags", {24'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_op, bus.as_sub,
                           bus.mul_strb, bus.mul_result_ack, bus.div_start}, 32'd0);
    check("midrst_unit_a", bus.unit_a, 32'd0);
    check("midrst_result", bus.rsp_result, 32'd0);
    check("midrst_req_ready_after", 32'(bus.req_ready), 32'd1);
    step();
    check("midrst_stays_idle", {30'd0, bus.req_ready, bus.div_start}, 32'd2);

    // ---------------- ADD after reset ----------------
    bus.as_result = 32'h4000_0000;
    issue(2'd0, 32'h3F80_0000, 32'h3F80_0000);
    step();
    check("add2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("add2_result", bus.rsp_result, 32'h4000_0000);
    check("add2_op_err", {29'd0, bus.rsp_op, bus.rsp_err}, 32'd0);
    step();
    check("add2_back_idle", 32'(bus.req_ready), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
